// File: rtl/linear_layer_start_fifo_ctrl.sv
// linear_layer_start_fifo_ctrl: shift-register start-token FIFO with registered full/empty flags.
// Define START_FIFO_NUM_VALID_EN to expose the if_num_data_valid and if_fifo_cap ports.
module linear_layer_start_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
`ifdef START_FIFO_NUM_VALID_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
`endif
);
  localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 2);
  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [ADDR_WIDTH:0]   ptr;
  logic                  push, pop;
  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;
  // ptr holds occupancy-1, so it directly addresses the oldest entry
  assign if_dout = srl[ptr[ADDR_WIDTH-1:0]];
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) srl[i] <= srl[i-1];
      srl[0] <= if_din;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '1;
      if_full_n  <= 1'b1;
      if_empty_n <= 1'b0;
    end else if (push && !pop) begin
      ptr        <= ptr + 1'b1;
      if_empty_n <= 1'b1;
      if (ptr == PTR_LAST) if_full_n <= 1'b0;
    end else if (pop && !push) begin
      ptr       <= ptr - 1'b1;
      if_full_n <= 1'b1;
      if (ptr == '0) if_empty_n <= 1'b0;
    end
  end
`ifdef START_FIFO_NUM_VALID_EN
  assign if_num_data_valid = ptr + 1'b1;
  assign if_fifo_cap       = (ADDR_WIDTH+1)'(DEPTH);
`endif
endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// tb_linear_layer_start_fifo_ctrl: directed checks on a DEPTH=2 FIFO and a randomized
// queue-model comparison on a DEPTH=4 FIFO.
module tb_linear_layer_start_fifo_ctrl;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;

  logic       a_wce = 1, a_write = 0, a_rce = 1, a_read = 0, a_full_n, a_empty_n;
  logic [3:0] a_din = 0, a_dout;
  logic       b_wce = 1, b_write = 0, b_rce = 1, b_read = 0, b_full_n, b_empty_n;
  logic [7:0] b_din = 0, b_dout;
`ifdef START_FIFO_NUM_VALID_EN
  logic [1:0] a_cnt, a_cap;
  logic [2:0] b_cnt, b_cap;
`endif

  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .if_write_ce(a_wce), .if_write(a_write), .if_din(a_din),
    .if_full_n(a_full_n), .if_read_ce(a_rce), .if_read(a_read), .if_dout(a_dout),
    .if_empty_n(a_empty_n)
`ifdef START_FIFO_NUM_VALID_EN
    , .if_num_data_valid(a_cnt), .if_fifo_cap(a_cap)
`endif
  );

  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .if_write_ce(b_wce), .if_write(b_write), .if_din(b_din),
    .if_full_n(b_full_n), .if_read_ce(b_rce), .if_read(b_read), .if_dout(b_dout),
    .if_empty_n(b_empty_n)
`ifdef START_FIFO_NUM_VALID_EN
    , .if_num_data_valid(b_cnt), .if_fifo_cap(b_cap)
`endif
  );

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic drive_a(input logic w, input logic [3:0] d, input logic r,
                         input logic wce = 1, input logic rce = 1);
    a_write = w; a_din = d; a_read = r; a_wce = wce; a_rce = rce;
    @(posedge clk); #1;
    a_write = 0; a_read = 0; a_wce = 1; a_rce = 1;
  endtask

  task automatic test_reset();
    a_write = 1; a_din = 4'hF;
    do_reset();
    a_write = 0;
    checks++; if (a_full_n !== 1'b1) begin failures++; $display("FAIL reset_full_n got=%b exp=1", a_full_n); end
    checks++; if (a_empty_n !== 1'b0) begin failures++; $display("FAIL reset_empty_n got=%b exp=0", a_empty_n); end
    checks++; if (b_empty_n !== 1'b0 || b_full_n !== 1'b1) begin failures++; $display("FAIL reset_b_flags got=%b%b exp=01", b_empty_n, b_full_n); end
`ifdef START_FIFO_NUM_VALID_EN
    checks++; if (a_cnt !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
    checks++; if (a_cap !== 2'd2) begin failures++; $display("FAIL fifo_cap got=%0d exp=2", a_cap); end
`endif
  endtask

  task automatic test_fill();
    drive_a(1, 4'h3, 0);
    checks++; if (a_empty_n !== 1'b1) begin failures++; $display("FAIL fill1_empty_n got=%b exp=1", a_empty_n); end
    checks++; if (a_full_n !== 1'b1) begin failures++; $display("FAIL fill1_full_n got=%b exp=1", a_full_n); end
    checks++; if (a_dout !== 4'h3) begin failures++; $display("FAIL fill1_dout got=%h exp=3", a_dout); end
    drive_a(1, 4'h5, 0);
    checks++; if (a_full_n !== 1'b0) begin failures++; $display("FAIL fill2_full_n got=%b exp=0", a_full_n); end
    checks++; if (a_dout !== 4'h3) begin failures++; $display("FAIL fill2_dout got=%h exp=3", a_dout); end
`ifdef START_FIFO_NUM_VALID_EN
    checks++; if (a_cnt !== 2'd2) begin failures++; $display("FAIL fill2_count got=%0d exp=2", a_cnt); end
`endif
  endtask

  task automatic test_drain();
    drive_a(0, 0, 1);
    checks++; if (a_full_n !== 1'b1) begin failures++; $display("FAIL drain1_full_n got=%b exp=1", a_full_n); end
    checks++; if (a_empty_n !== 1'b1) begin failures++; $display("FAIL drain1_empty_n got=%b exp=1", a_empty_n); end
    checks++; if (a_dout !== 4'h5) begin failures++; $display("FAIL drain1_dout got=%h exp=5", a_dout); end
    drive_a(0, 0, 1);
    checks++; if (a_empty_n !== 1'b0) begin failures++; $display("FAIL drain2_empty_n got=%b exp=0", a_empty_n); end
`ifdef START_FIFO_NUM_VALID_EN
    checks++; if (a_cnt !== 2'd0) begin failures++; $display("FAIL drain2_count got=%0d exp=0", a_cnt); end
`endif
  endtask

  task automatic test_overflow_underflow();
    drive_a(1, 4'h3, 0);
    drive_a(1, 4'h5, 0);
    drive_a(1, 4'h9, 0);
    checks++; if (a_full_n !== 1'b0 || a_dout !== 4'h3) begin failures++; $display("FAIL overflow_hold got=%b/%h exp=0/3", a_full_n, a_dout); end
    drive_a(0, 0, 1);
    checks++; if (a_dout !== 4'h5) begin failures++; $display("FAIL overflow_second got=%h exp=5", a_dout); end
    drive_a(0, 0, 1);
    checks++; if (a_empty_n !== 1'b0) begin failures++; $display("FAIL overflow_drained got=%b exp=0", a_empty_n); end
    drive_a(0, 0, 1);
    checks++; if (a_empty_n !== 1'b0 || a_full_n !== 1'b1) begin failures++; $display("FAIL underflow_flags got=%b%b exp=01", a_empty_n, a_full_n); end
    drive_a(1, 4'h6, 0);
    checks++; if (a_empty_n !== 1'b1 || a_full_n !== 1'b1 || a_dout !== 4'h6) begin failures++; $display("FAIL underflow_recover got=%b%b/%h exp=11/6", a_empty_n, a_full_n, a_dout); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_a(1, 4'h3, 0);
    drive_a(1, 4'h7, 1);
    checks++; if (a_empty_n !== 1'b1 || a_full_n !== 1'b1) begin failures++; $display("FAIL simul1_flags got=%b%b exp=11", a_empty_n, a_full_n); end
    checks++; if (a_dout !== 4'h7) begin failures++; $display("FAIL simul1_dout got=%h exp=7", a_dout); end
    drive_a(1, 4'h8, 0);
    checks++; if (a_full_n !== 1'b0 || a_dout !== 4'h7) begin failures++; $display("FAIL simul_full got=%b/%h exp=0/7", a_full_n, a_dout); end
    drive_a(1, 4'hC, 1);
    checks++; if (a_full_n !== 1'b1 || a_empty_n !== 1'b1 || a_dout !== 4'h8) begin failures++; $display("FAIL simul_full_both got=%b%b/%h exp=11/8", a_full_n, a_empty_n, a_dout); end
`ifdef START_FIFO_NUM_VALID_EN
    checks++; if (a_cnt !== 2'd1) begin failures++; $display("FAIL simul_full_count got=%0d exp=1", a_cnt); end
`endif
  endtask

  task automatic test_clock_enables();
    drive_a(1, 4'hB, 0, 0, 1);
    checks++; if (a_empty_n !== 1'b1 || a_full_n !== 1'b1 || a_dout !== 4'h8) begin failures++; $display("FAIL wce_off got=%b%b/%h exp=11/8", a_empty_n, a_full_n, a_dout); end
    drive_a(0, 0, 1, 1, 0);
    checks++; if (a_empty_n !== 1'b1 || a_full_n !== 1'b1 || a_dout !== 4'h8) begin failures++; $display("FAIL rce_off got=%b%b/%h exp=11/8", a_empty_n, a_full_n, a_dout); end
`ifdef START_FIFO_NUM_VALID_EN
    checks++; if (a_cnt !== 2'd1) begin failures++; $display("FAIL ce_count got=%0d exp=1", a_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    drive_a(1, 4'h2, 0);
    checks++; if (a_full_n !== 1'b0) begin failures++; $display("FAIL mid_prefull got=%b exp=0", a_full_n); end
    reset = 1; a_write = 1; a_din = 4'h4;
    @(posedge clk); #1;
    reset = 0; a_write = 0;
    checks++; if (a_empty_n !== 1'b0 || a_full_n !== 1'b1) begin failures++; $display("FAIL mid_reset_flags got=%b%b exp=01", a_empty_n, a_full_n); end
`ifdef START_FIFO_NUM_VALID_EN
    checks++; if (a_cnt !== 2'd0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", a_cnt); end
`endif
    drive_a(1, 4'hA, 0);
    checks++; if (a_empty_n !== 1'b1 || a_dout !== 4'hA) begin failures++; $display("FAIL mid_reset_push got=%b/%h exp=1/a", a_empty_n, a_dout); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    bit w, wc, r, rc, push, pop, rst;
    logic [7:0] d;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      w = $urandom_range(0, 1); wc = $urandom_range(0, 7) != 0;
      r = $urandom_range(0, 1); rc = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 79) == 0;
      d = 8'($urandom);
      b_write = w; b_wce = wc; b_read = r; b_rce = rc; b_din = d; reset = rst;
      push = w && wc && q.size() < 4;
      pop = r && rc && q.size() > 0;
      @(posedge clk); #1;
      reset = 0;
      if (rst) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
      end
      checks++; if (b_empty_n !== (q.size() > 0)) begin failures++; $display("FAIL rand_empty_n cyc=%0d got=%b exp=%b", n, b_empty_n, q.size() > 0); end
      checks++; if (b_full_n !== (q.size() < 4)) begin failures++; $display("FAIL rand_full_n cyc=%0d got=%b exp=%b", n, b_full_n, q.size() < 4); end
      if (q.size() > 0) begin
        checks++; if (b_dout !== q[0]) begin failures++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", n, b_dout, q[0]); end
      end
`ifdef START_FIFO_NUM_VALID_EN
      checks++; if (b_cnt !== 3'(q.size())) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, b_cnt, q.size()); end
`endif
    end
    b_write = 0; b_read = 0; b_wce = 1; b_rce = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_clock_enables();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
